// File: rtl/uart_tx.sv
// uart_tx: 8N1 LSB-first UART transmitter with a small byte FIFO on a valid/ready input
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_dv,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_active,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);
  localparam logic [PW:0]   FULL     = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic          run;
  logic [CW-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shift, shift_nx;
  logic          serial_nx, active_nx, done_nx;
  logic          push, pop, bit_end;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nx;

  assign push     = tx_dv & tx_ready & run;
  assign bit_end  = clk_cnt == CNT_LAST;
  assign count_nx = count + (PW + 1)'(push) - (PW + 1)'(pop);

  // Reset assertion is immediate; release takes effect one edge later so logic leaves reset cleanly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;

  // FIFO storage; contents need no reset because the count gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= tx_byte;

  // FIFO pointers, occupancy and the registered not-full flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_ready <= 1'b1;
    end else if (run) begin
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count_nx;
      tx_ready <= count_nx != FULL;
    end

  // Framing FSM: next state, next line level and the pop request; done is registered so it lands on the last stop cycle
  always_comb begin
    state_nx   = state;
    clk_cnt_nx = bit_end ? '0 : clk_cnt + 1'b1;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    serial_nx  = tx_serial;
    active_nx  = tx_active;
    done_nx    = state == STOP && clk_cnt == CNT_DONE;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nx = '0;
        serial_nx  = 1'b1;
        active_nx  = 1'b0;
        if (count != '0) begin
          pop       = 1'b1;
          shift_nx  = mem[rd_ptr];
          state_nx  = START;
          serial_nx = 1'b0;
          active_nx = 1'b1;
        end
      end
      START:
        if (bit_end) begin
          state_nx   = DATA;
          bit_idx_nx = '0;
          serial_nx  = shift[0];
        end
      DATA:
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx  = STOP;
            serial_nx = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            serial_nx  = shift[bit_idx + 3'd1];
          end
        end
      STOP:
        if (bit_end) begin
          if (count != '0) begin
            pop       = 1'b1;
            shift_nx  = mem[rd_ptr];
            state_nx  = START;
            serial_nx = 1'b0;
          end else begin
            state_nx  = IDLE;
            active_nx = 1'b0;
          end
        end
      default: state_nx = IDLE;
    endcase
  end

  // Framing FSM state and registered line outputs; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else if (run) begin
      state     <= state_nx;
      clk_cnt   <= clk_cnt_nx;
      bit_idx   <= bit_idx_nx;
      shift     <= shift_nx;
      tx_serial <= serial_nx;
      tx_active <= active_nx;
      tx_done   <= done_nx;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a behavioural line receiver
module tb_uart_tx;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_byte = '0;
  logic       tx_dv = 1'b0;
  logic       tx_ready, tx_serial, tx_active, tx_done;
  logic [7:0] rx_q [$];
  int         errors = 0;
  int         checks = 0;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte), .tx_dv(tx_dv),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_active(tx_active), .tx_done(tx_done)
  );

  always #10 clk = ~clk;

  // Mid-bit sampling receiver standing in for the loopback UART_RX
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (tx_serial === 1'b0) begin
      repeat (C / 2) @(negedge clk);
      if (tx_serial === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx_serial;
        end
        repeat (C) @(negedge clk);
        if (tx_serial === 1'b1) rx_q.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_start();
    int ok = 0;
    for (int i = 0; i < 400 && ok == 0; i++)
      if (tx_serial === 1'b0) ok = 1;
      else @(negedge clk);
    check("start_seen", ok, 1);
  endtask

  // Called on the first negedge of a start bit; returns on the first negedge after the frame
  task automatic check_frame(input logic [7:0] b);
    logic [9:0] exp = {1'b1, b, 1'b0};
    logic [9:0] got = '0;
    int bad = 0;
    for (int i = 0; i < 10 * C; i++) begin
      if (i % C == C / 2) got[i / C] = tx_serial;
      if (tx_serial !== exp[i / C] || tx_active !== 1'b1 || tx_done !== (i == 10 * C - 1)) bad++;
      @(negedge clk);
    end
    check("frame_bits", got, exp);
    check("frame_cycles", bad, 0);
  endtask

  task automatic send_one(input logic [7:0] b);
    tx_byte = b;
    tx_dv = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    check("latency_idle", tx_serial, 1);
    @(negedge clk);
    check("latency_start", tx_serial, 0);
    check_frame(b);
    check("idle_active", tx_active, 0);
    check("idle_ready", tx_ready, 1);
  endtask

  task automatic quiet(input string tag, input int n);
    int lows = 0;
    int dones = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_serial !== 1'b1) lows++;
      if (tx_done !== 1'b0) dones++;
      @(negedge clk);
    end
    check(tag, lows, 0);
    check({tag, "_done"}, dones, 0);
  endtask

  initial begin
    logic [7:0] b2b  [6] = '{8'h41, 8'h42, 8'h55, 8'hAA, 8'h0F, 8'hF0};
    logic [7:0] full [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] lb   [3] = '{8'h00, 8'hFF, 8'h41};
    repeat (5) @(negedge clk);
    check("rst_serial", tx_serial, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_active", tx_active, 0);
    check("rst_done", tx_done, 0);
    tx_byte = 8'h41;
    tx_dv = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    quiet("sync_no_accept", 3 * C);

    rx_q.delete();
    send_one(8'h41);
    repeat (C) @(negedge clk);
    check("single_rx_count", rx_q.size(), 1);
    check("single_rx_byte", rx_q[0], 8'h41);

    tx_byte = 8'h42;
    tx_dv = 1'b1;
    @(negedge clk);
    tx_byte = 8'h13;
    @(negedge clk);
    tx_dv = 1'b0;
    wait_start();
    repeat (4 * C + 5) @(negedge clk);
    check("bit3_level", tx_serial, 0);
    #3 rst_n = 1'b0;
    #1;
    check("async_serial", tx_serial, 1);
    check("async_ready", tx_ready, 1);
    check("async_active", tx_active, 0);
    check("async_done", tx_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet("after_abort", 20 * C);
    send_one(8'h42);

    fork
      begin
        int ok = 0;
        for (int i = 0; i < 6; i++) begin
          check("b2b_ready", tx_ready, i < 5);
          tx_byte = b2b[i];
          tx_dv = 1'b1;
          @(negedge clk);
        end
        for (int k = 0; k < 400 && ok == 0; k++)
          if (tx_ready) ok = 1;
          else @(negedge clk);
        check("b2b_sixth_accept", ok, 1);
        @(negedge clk);
        tx_dv = 1'b0;
      end
      begin
        wait_start();
        for (int j = 0; j < 6; j++) check_frame(b2b[j]);
        check("b2b_idle", tx_active, 0);
      end
    join

    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      tx_byte = full[i];
      tx_dv = 1'b1;
      @(negedge clk);
    end
    tx_byte = 8'h99;
    for (int i = 0; i < 5; i++) begin
      check("full_ready", tx_ready, 0);
      @(negedge clk);
    end
    tx_dv = 1'b0;
    repeat (54 * C) @(negedge clk);
    check("full_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) check("full_rx_order", rx_q[i], full[i]);
    check("full_idle", tx_active, 0);

    rx_q.delete();
    for (int i = 0; i < 3; i++) begin
      tx_byte = lb[i];
      tx_dv = 1'b1;
      @(negedge clk);
    end
    tx_dv = 1'b0;
    repeat (34 * C) @(negedge clk);
    check("loop_rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) check("loop_rx_byte", rx_q[i], lb[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
